alu_wb_stage: RTL

- Pipeline stage directly downstream of the ALU: captures the ALU result, destination and NZVC flags into a 2-entry skid buffer with valid/ready handshake on both sides.
- Holds the architectural NZVC status register and evaluates each instruction's condition code against it; a failed condition annuls the write.
- Output feeds register-file writeback.

---
 rtl/alu_wb_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback stage, 2-entry skid buffer, NZVC flags.
// Optional perf counters with WB_PERF_CNT_EN.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_v,
  input  logic              in_c,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_setf,
  input  logic [3:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_annul,
  output logic [3:0]        flags_nzvc
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       annul_cnt
`endif
);

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              annul;
  } ent_t;

  ent_t       main_q, main_d;
  ent_t       skid_q, skid_d;
  ent_t       new_e;
  logic [3:0] flags_q, flags_d;
  logic       pass;
  logic       acc;
  logic       fire;
  logic       fn, fz, fv, fc;

  assign {fn, fz, fv, fc} = flags_q;
  assign in_ready = !skid_q.v && !flush;
  assign acc      = in_valid && in_ready;
  assign fire     = main_q.v && out_ready;

  // Condition code test against the committed flags.
  always_comb begin
    pass = 1'b0;
    unique case (in_cond)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc && !fz;
      4'h9: pass = !fc || fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = !fz && (fn == fv);
      4'hD: pass = fz || (fn != fv);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
    endcase
  end

  // Buffer and flag next-state.
  always_comb begin
    new_e.v     = 1'b1;
    new_e.data  = in_result;
    new_e.rd    = in_rd;
    new_e.we    = in_we && pass;
    new_e.annul = !pass;
    main_d  = main_q;
    skid_d  = skid_q;
    flags_d = flags_q;
    if (acc && pass && in_setf)
      flags_d = {in_n, in_z, in_v, in_c};
    if (flush) begin
      main_d.v = 1'b0;
      skid_d.v = 1'b0;
    end else if (fire && skid_q.v) begin
      main_d   = skid_q;
      skid_d.v = 1'b0;
    end else if (acc && (!main_q.v || fire)) begin
      main_d = new_e;
    end else if (acc) begin
      skid_d = new_e;
    end else if (fire) begin
      main_d.v = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      flags_q <= '0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid  = main_q.v;
  assign out_data   = main_q.data;
  assign out_rd     = main_q.rd;
  assign out_we     = main_q.we;
  assign out_annul  = main_q.annul;
  assign flags_nzvc = flags_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] ret_q, ret_d;
  logic [31:0] ann_q, ann_d;

  // Count retired and annulled output transfers.
  always_comb begin
    ret_d = ret_q;
    ann_d = ann_q;
    if (fire && !main_q.annul) ret_d = ret_q + 32'd1;
    if (fire && main_q.annul)  ann_d = ann_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
      ann_q <= '0;
    end else begin
      ret_q <= ret_d;
      ann_q <= ann_d;
    end
  end

  assign retired_cnt = ret_q;
  assign annul_cnt   = ann_q;
`endif

endmodule
